sta_mirror_updater: RTL and testbench
=====================================

Name: sta_mirror_updater

Overview:
- Statistics accumulator directly upstream of the distributed SDP mirror RAM.
- Accepts indexed increment events, keeps a local shadow copy of every counter, and performs the read-modify-write on that copy.
- Writes each updated counter value to the mirror RAM through its write port (wr_en/wr_addr/wr_data, wr_clk domain). The mirror's read side is then free for any rd_clk consumer.
- Also runs a full-table clear sweep on reset and on request.

Parameters:
- ADDR_WIDTH, 4, counter index width; 2**ADDR_WIDTH entries; range 4-10; must match the mirror RAM.
- DATA_WIDTH, 32, counter width; must match the mirror RAM; range 2-256.
- INC_WIDTH, 8, event increment width; 1..DATA_WIDTH.
- SATURATE, 1, 1 = saturate at all-ones; 0 = modulo 2**DATA_WIDTH wrap.

Ports:
- wr_clk, in, 1, single clock for the whole block; it is also the mirror RAM write clock.
- asyn_rst, in, 1, reset: asynchronous assert, active-high.
- evt_valid, in, 1, event present.
- evt_ready, out, 1, block can accept an event this cycle.
- evt_idx, in, ADDR_WIDTH, counter index.
- evt_inc, in, INC_WIDTH, increment, zero-extended to DATA_WIDTH.
- clear_req, in, 1, single-cycle request to zero all counters.
- clear_busy, out, 1, clear sweep in progress.
- clear_done, out, 1, one-cycle pulse when a sweep finishes.
- sat_flag, out, 1, sticky: some counter saturated (SATURATE=1) or wrapped (SATURATE=0).
- wr_en, out, 1, mirror RAM write enable.
- wr_addr, out, ADDR_WIDTH, mirror RAM write address.
- wr_data, out, DATA_WIDTH, mirror RAM write data.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, evt_ready=0, clear_busy=1, clear_done=0, sat_flag=0, FSM=CLEAR, sweep pointer=0.
- The shadow array has no reset; the post-reset sweep initialises it.
- FSM states:
  - IDLE: evt_ready=1.
  - DRAIN: one cycle, evt_ready=0, lets the in-flight stage-1 event retire.
  - CLEAR: evt_ready=0, clear_busy=1.
- FSM transitions:
  - IDLE + clear_req goes to DRAIN if stage 1 is valid, otherwise directly to CLEAR.
  - DRAIN always goes to CLEAR.
  - CLEAR with pointer == 2**ADDR_WIDTH-1 goes to IDLE. clear_done pulses in the first IDLE cycle.
- Event accept: evt_valid & evt_ready at rising edge E0. Events presented while evt_ready=0 are not accepted; the source must hold them.
- Pipeline, at E0:
  - stage 1 captures idx, inc, and old = shadow[evt_idx];
  - forwarding: if stage 1 is valid and stage-1 idx == evt_idx, old takes the stage-1 sum instead of the shadow value.
- Pipeline, at E1:
  - sum = old + zero-extended inc is written to shadow[idx];
  - output registers load wr_en=1, wr_addr=idx, wr_data=sum.
- Latency: wr_en is high in the cycle after E1, i.e. 2 edges after acceptance.
- Throughput: 1 event per cycle, including back-to-back events on the same index.
- Arithmetic:
  - Sum is formed DATA_WIDTH+1 bits wide; the carry bit means overflow.
  - On overflow with SATURATE=1, the result is all-ones.
  - On overflow with SATURATE=0, the result is the low DATA_WIDTH bits.
  - Either overflow case sets sat_flag.
- evt_inc=0 still produces a mirror write of the unchanged value.
- CLEAR:
  - each cycle writes 0 to shadow[ptr] and drives wr_en=1, wr_addr=ptr, wr_data=0 (registered, one cycle later); ptr then increments;
  - full sweep = 2**ADDR_WIDTH writes, addresses 0..2**ADDR_WIDTH-1 in order;
  - the pointer wraps to 0 at exit;
  - sat_flag is cleared on entry to CLEAR.
- clear_req during DRAIN or CLEAR is ignored; no queued second sweep.
- clear_req and an accepted event in the same IDLE cycle: the event is accepted; it retires in DRAIN before the sweep, so the sweep overwrites it.
- wr_en is 0 in every cycle with no event retiring and no sweep write.
- asyn_rst mid-sweep or mid-pipeline:
  - all outputs return immediately to reset values;
  - in-flight events are discarded;
  - a fresh full sweep starts after release.

Test Plan:
- Reset release, ADDR_WIDTH=4 -> clear_busy=1 for 16 cycles; wr_en=1 with wr_addr 0..15, wr_data=0; clear_done pulses once; evt_ready rises with it.
- Single event idx=3, inc=5 -> two edges after acceptance, wr_en=1, wr_addr=3, wr_data=5. A second event idx=3, inc=2 -> wr_data=7.
- Back-to-back events idx=7 with inc 1,1,1,1 on consecutive cycles -> four consecutive writes to address 7 with data 1,2,3,4; forwarding is exercised.
- SATURATE=1, DATA_WIDTH=8: counter at 0xFE, inc=5 -> wr_data=0xFF, sat_flag=1; a further inc=1 -> 0xFF.
- SATURATE=0: counter at 0xFE, inc=5 -> wr_data=0x03, sat_flag=1.
- clear_req together with accepted event idx=2, inc=9 -> event write (addr 2, data 9) appears, then DRAIN, then the 16-write zero sweep. Address 2 reads 0 afterwards; sat_flag=0. asyn_rst asserted mid-sweep restarts the sweep at address 0.

Source files
------------

// File: rtl/sta_mirror_updater.sv
// Statistics accumulator feeding the write port of the SDP mirror RAM.
// Keeps a local shadow of every counter, does the read-modify-write on that
// shadow through a two-stage pipeline, and mirrors each new value to the RAM.
// A full-table zero sweep runs after reset and on request.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting events
// DRAIN  | one cycle to let the event in stage 1 retire before the sweep
// CLEAR  | zero sweep, one address per cycle, 0 .. 2**ADDR_WIDTH-1
module sta_mirror_updater #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int INC_WIDTH  = 8,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic [ADDR_WIDTH-1:0] evt_idx,
    input  logic [INC_WIDTH-1:0]  evt_inc,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  sat_flag,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic                    evt_ready_q;
    logic                    clear_busy_q;
    logic                    clear_done_q;
    logic                    sat_flag_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic                    s1_valid_q;
    logic [ADDR_WIDTH-1:0]   s1_idx_q;
    logic [INC_WIDTH-1:0]    s1_inc_q;
    logic [DATA_WIDTH-1:0]   s1_old_q;

    logic [DATA_WIDTH-1:0]   shadow_q [DEPTH];

    logic                    accept;
    logic [DATA_WIDTH:0]     sum_d;
    logic                    ovf_d;
    logic [DATA_WIDTH-1:0]   res_d;
    logic [DATA_WIDTH-1:0]   old_d;

    assign accept     = evt_valid & evt_ready_q;
    assign evt_ready  = evt_ready_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign sat_flag   = sat_flag_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    // Stage-2 sum with carry, and stage-1 operand fetch with forwarding of the
    // sum being retired this cycle so same-index back-to-back events chain.
    always_comb begin
        sum_d = {1'b0, s1_old_q} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, s1_inc_q};
        ovf_d = sum_d[DATA_WIDTH];
        res_d = (ovf_d && SATURATE) ? {DATA_WIDTH{1'b1}} : sum_d[DATA_WIDTH-1:0];
        old_d = shadow_q[evt_idx];
        if (s1_valid_q && (s1_idx_q == evt_idx)) begin
            old_d = res_d;
        end
    end

    // Shadow counter array: sweep zeroes it, retiring events update it.
    // No reset; the post-reset sweep initialises every entry.
    always_ff @(posedge wr_clk) begin
        if (state_q == ST_CLEAR) begin
            shadow_q[ptr_q] <= '0;
        end else if (s1_valid_q) begin
            shadow_q[s1_idx_q] <= res_d;
        end
    end

    // Control FSM, event pipeline and registered mirror-write outputs.
    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            evt_ready_q  <= 1'b0;
            clear_busy_q <= 1'b1;
            clear_done_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_inc_q     <= '0;
            s1_old_q     <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            clear_done_q <= 1'b0;

            s1_valid_q <= accept;
            if (accept) begin
                s1_idx_q <= evt_idx;
                s1_inc_q <= evt_inc;
                s1_old_q <= old_d;
            end

            if (s1_valid_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= s1_idx_q;
                wr_data_q <= res_d;
                if (ovf_d) begin
                    sat_flag_q <= 1'b1;
                end
            end

            // Sweep entry clears sat_flag last so it wins over an event that
            // retires on the same edge; the sweep overwrites that event anyway.
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        evt_ready_q  <= 1'b0;
                        clear_busy_q <= 1'b1;
                        if (accept || s1_valid_q) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q    <= ST_CLEAR;
                            sat_flag_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q    <= ST_CLEAR;
                    sat_flag_q <= 1'b0;
                end
                ST_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= ptr_q;
                    wr_data_q <= '0;
                    ptr_q     <= ptr_q + ADDR_WIDTH'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_q      <= ST_IDLE;
                        evt_ready_q  <= 1'b1;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sta_mirror_updater.sv
// Bench for sta_mirror_updater: a saturating and a wrapping instance share one
// stimulus stream; a reference model pushes expected mirror writes into one
// queue per instance and a negedge monitor pops and compares every write.
`timescale 1ns/1ps
module tb_sta_mirror_updater;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int IW = 8;

    logic          wr_clk = 1'b0;
    logic          asyn_rst = 1'b0;
    logic          evt_valid = 1'b0;
    logic [AW-1:0] evt_idx = '0;
    logic [IW-1:0] evt_inc = '0;
    logic          clear_req = 1'b0;

    logic          s_evt_ready, s_clear_busy, s_clear_done, s_sat_flag, s_wr_en;
    logic [AW-1:0] s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic          w_evt_ready, w_clear_busy, w_clear_done, w_sat_flag, w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;

    int errors = 0;
    int checks = 0;

    logic [AW+DW-1:0] q_sat[$];
    logic [AW+DW-1:0] q_wrap[$];
    logic [DW-1:0]    m_sat[16];
    logic [DW-1:0]    m_wrap[16];
    logic             exp_sat_s = 1'b0;
    logic             exp_sat_w = 1'b0;
    logic [AW+DW-1:0] mon_exp_s, mon_exp_w;

    sta_mirror_updater #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW), .SATURATE(1'b1)) u_sat (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .evt_valid(evt_valid), .evt_ready(s_evt_ready),
        .evt_idx(evt_idx), .evt_inc(evt_inc), .clear_req(clear_req), .clear_busy(s_clear_busy),
        .clear_done(s_clear_done), .sat_flag(s_sat_flag), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data)
    );

    sta_mirror_updater #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW), .SATURATE(1'b0)) u_wrap (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .evt_valid(evt_valid), .evt_ready(w_evt_ready),
        .evt_idx(evt_idx), .evt_inc(evt_inc), .clear_req(clear_req), .clear_busy(w_clear_busy),
        .clear_done(w_clear_done), .sat_flag(w_sat_flag), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data)
    );

    always #5 wr_clk = ~wr_clk;

    // Scoreboard monitor: every mirror write must match the oldest expected one.
    always @(negedge wr_clk) begin
        if (s_wr_en === 1'b1) begin
            checks++;
            if (q_sat.size() == 0) begin
                errors++;
                $display("FAIL sat_write: got addr=%0d data=%02h, required no write", s_wr_addr, s_wr_data);
            end else begin
                mon_exp_s = q_sat.pop_front();
                if ({s_wr_addr, s_wr_data} !== mon_exp_s) begin
                    errors++;
                    $display("FAIL sat_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             s_wr_addr, s_wr_data, mon_exp_s[AW+DW-1:DW], mon_exp_s[DW-1:0]);
                end
            end
        end
        if (w_wr_en === 1'b1) begin
            checks++;
            if (q_wrap.size() == 0) begin
                errors++;
                $display("FAIL wrap_write: got addr=%0d data=%02h, required no write", w_wr_addr, w_wr_data);
            end else begin
                mon_exp_w = q_wrap.pop_front();
                if ({w_wr_addr, w_wr_data} !== mon_exp_w) begin
                    errors++;
                    $display("FAIL wrap_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             w_wr_addr, w_wr_data, mon_exp_w[AW+DW-1:DW], mon_exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic push_evt(input logic [AW-1:0] idx, input logic [IW-1:0] inc);
        logic [DW:0] s;
        s = {1'b0, m_sat[idx]} + {1'b0, inc};
        m_sat[idx] = s[DW] ? {DW{1'b1}} : s[DW-1:0];
        if (s[DW]) exp_sat_s = 1'b1;
        q_sat.push_back({idx, m_sat[idx]});
        s = {1'b0, m_wrap[idx]} + {1'b0, inc};
        m_wrap[idx] = s[DW-1:0];
        if (s[DW]) exp_sat_w = 1'b1;
        q_wrap.push_back({idx, m_wrap[idx]});
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 16; i++) begin
            q_sat.push_back({AW'(i), {DW{1'b0}}});
            q_wrap.push_back({AW'(i), {DW{1'b0}}});
            m_sat[i] = '0;
            m_wrap[i] = '0;
        end
        exp_sat_s = 1'b0;
        exp_sat_w = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_evt(input logic [AW-1:0] idx, input logic [IW-1:0] inc);
        bit got;
        got = 0;
        evt_valid = 1'b1;
        evt_idx   = idx;
        evt_inc   = inc;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge wr_clk);
            if (s_evt_ready === 1'b1) begin
                got = 1;
                push_evt(idx, inc);
            end
            @(posedge wr_clk);
            #1;
        end
        evt_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_evt_timeout: evt_ready stayed %b, required 1", s_evt_ready);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge wr_clk);
            if (s_clear_done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: clear_done=%b, required 1", name, s_clear_done);
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_cnt, done_cnt;
        logic rdy_at_done;
        busy_cnt = 0;
        done_cnt = 0;
        rdy_at_done = 1'b0;
        #1;
        asyn_rst = 1'b1;
        q_sat.delete();
        q_wrap.delete();
        push_sweep();
        repeat (2) @(negedge wr_clk);
        checks++;
        if ({s_wr_en, s_evt_ready, s_clear_busy, s_clear_done, s_sat_flag} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: got en/rdy/busy/done/sat=%b, required 00100",
                     {s_wr_en, s_evt_ready, s_clear_busy, s_clear_done, s_sat_flag});
        end
        checks++;
        if ({s_wr_addr, s_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0d data=%02h, required 0/00", s_wr_addr, s_wr_data);
        end
        checks++;
        if ({w_wr_en, w_evt_ready, w_clear_busy, w_sat_flag} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_wrap_flags: got en/rdy/busy/sat=%b, required 0010",
                     {w_wr_en, w_evt_ready, w_clear_busy, w_sat_flag});
        end
        @(posedge wr_clk);
        #1;
        asyn_rst = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(negedge wr_clk);
            if (s_clear_busy === 1'b1) busy_cnt++;
            if (s_clear_done === 1'b1) begin
                done_cnt++;
                rdy_at_done = s_evt_ready;
            end
        end
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL reset_busy_cycles: got %0d, required 16", busy_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL reset_done_pulses: got %0d, required 1", done_cnt);
        end
        checks++;
        if (rdy_at_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_with_done: got %b, required 1", rdy_at_done);
        end
        checks++;
        if ({s_sat_flag, w_sat_flag} !== 2'b00) begin
            errors++;
            $display("FAIL reset_sat_flag: got %b, required 00", {s_sat_flag, w_sat_flag});
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_single();
        send_evt(4'd3, 8'd5);
        @(negedge wr_clk);
        checks++;
        if (s_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: wr_en=%b one edge after accept, required 0", s_wr_en);
        end
        @(negedge wr_clk);
        checks++;
        if ({s_wr_en, s_wr_addr, s_wr_data} !== {1'b1, 4'd3, 8'd5}) begin
            errors++;
            $display("FAIL single_latency: got en=%b addr=%0d data=%02h, required 1/3/05",
                     s_wr_en, s_wr_addr, s_wr_data);
        end
        @(posedge wr_clk);
        #1;
        send_evt(4'd3, 8'd2);
        repeat (3) @(posedge wr_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send_evt(4'd7, 8'd1);
        send_evt(4'd9, 8'd0);
        repeat (3) @(posedge wr_clk);
        #1;
    endtask

    task automatic test_overflow();
        checks++;
        if ({s_sat_flag, w_sat_flag} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_flag_before: got %b, required 00", {s_sat_flag, w_sat_flag});
        end
        send_evt(4'd5, 8'hFE);
        repeat (3) @(posedge wr_clk);
        #1;
        send_evt(4'd5, 8'd5);
        send_evt(4'd5, 8'd1);
        repeat (4) @(negedge wr_clk);
        checks++;
        if ({s_sat_flag, w_sat_flag} !== {exp_sat_s, exp_sat_w}) begin
            errors++;
            $display("FAIL ovf_sat_flag: got %b, required %b", {s_sat_flag, w_sat_flag},
                     {exp_sat_s, exp_sat_w});
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_clear_with_event();
        evt_valid = 1'b1;
        evt_idx   = 4'd2;
        evt_inc   = 8'd9;
        clear_req = 1'b1;
        @(negedge wr_clk);
        checks++;
        if (s_evt_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_evt_ready: got %b, required 1", s_evt_ready);
        end
        push_evt(4'd2, 8'd9);
        push_sweep();
        @(posedge wr_clk);
        #1;
        evt_valid = 1'b0;
        clear_req = 1'b0;
        repeat (5) @(posedge wr_clk);
        #1;
        checks++;
        if (s_clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy_mid: got %b, required 1", s_clear_busy);
        end
        clear_req = 1'b1;
        @(posedge wr_clk);
        #1;
        clear_req = 1'b0;
        wait_done("clear");
        checks++;
        if ({s_sat_flag, w_sat_flag} !== 2'b00) begin
            errors++;
            $display("FAIL clear_sat_flag: got %b, required 00", {s_sat_flag, w_sat_flag});
        end
        send_evt(4'd2, 8'd0);
        repeat (4) @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset_mid_sweep();
        send_evt(4'd4, 8'd3);
        clear_req = 1'b1;
        @(negedge wr_clk);
        push_sweep();
        @(posedge wr_clk);
        #1;
        clear_req = 1'b0;
        repeat (6) @(posedge wr_clk);
        #1;
        asyn_rst = 1'b1;
        q_sat.delete();
        q_wrap.delete();
        push_sweep();
        #1;
        checks++;
        if ({s_wr_en, s_evt_ready, s_clear_busy, s_clear_done, w_wr_en} !== 5'b00100) begin
            errors++;
            $display("FAIL midreset_flags: got en/rdy/busy/done/wen=%b, required 00100",
                     {s_wr_en, s_evt_ready, s_clear_busy, s_clear_done, w_wr_en});
        end
        @(posedge wr_clk);
        #1;
        asyn_rst = 1'b0;
        wait_done("midreset");
        send_evt(4'd4, 8'd1);
        repeat (4) @(posedge wr_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_sat[i] = '0;
            m_wrap[i] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clear_with_event();
        test_reset_mid_sweep();
        repeat (3) @(negedge wr_clk);
        checks++;
        if (q_sat.size() != 0) begin
            errors++;
            $display("FAIL sat_queue_drained: %0d writes outstanding, required 0", q_sat.size());
        end
        checks++;
        if (q_wrap.size() != 0) begin
            errors++;
            $display("FAIL wrap_queue_drained: %0d writes outstanding, required 0", q_wrap.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
